// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the multi-cycle CPU sequencer.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } seq_state_t;

  // Syscall ABI: service number in $v0, argument in $a0, service 10 = exit.
  localparam int SYSCALL_EXIT   = 10;
  localparam int SYSCALL_V0_REG = 2;
  localparam int SYSCALL_A0_REG = 4;

endpackage

// File: rtl/cpu_seq_counters.sv
// Performance counters for the sequencer: active cycles and committed
// instructions. Both wrap modulo 2^CNT_W.
module seq_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cyc_inc,
  input  logic             instr_inc,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  // Active-cycle counter, advanced while the core is doing work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count <= '0;
    end else if (cyc_inc) begin
      cycle_count <= cycle_count + CNT_W'(1);
    end
  end

  // Committed-instruction counter, advanced once per commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_count <= '0;
    end else if (instr_inc) begin
      instr_count <= instr_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with req/ack
// memory handshakes, syscall print/exit, run/stop at instruction boundaries
// and performance counters.
//
// Optional build macro: SEQ_TIMEOUT_EN
//   defined   - FETCH/MEM waits are bounded by MEM_TIMEOUT cycles; on expiry
//               the request drops, err is set (sticky) and the core halts.
//   undefined - waits are unbounded, err is tied low.
//
// state  | meaning
// IDLE   | stopped at an instruction boundary, waiting for run
// FETCH  | imem_req held until imem_ack; IR loaded in the ack cycle
// DECODE | syscall handling (print commits, exit halts), else to EXEC
// EXEC   | branch/jump commits here; loads/stores to MEM; ALU to WB
// MEM    | dmem_req held until dmem_ack; store commits, load goes to WB
// WB     | regfile write and PC commit together
// HALT   | terminal after exit syscall (or timeout) until reset
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DISP_W      = 32,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              is_load,
  input  logic              is_store,
  input  logic              writes_reg,
  input  logic              is_syscall,
  input  logic [DATA_W-1:0] sys_v0,
  input  logic [DATA_W-1:0] sys_a0,
  output logic              imem_req,
  input  logic              imem_ack,
  output logic              dmem_req,
  output logic              dmem_we,
  input  logic              dmem_ack,
  output logic              ir_we,
  output logic              pc_we,
  output logic              reg_we,
  output logic [2:0]        state,
  output logic              halted,
  output logic              err,
  output logic [DISP_W-1:0] display_syscall,
  output logic [CNT_W-1:0]  instr_count,
  output logic [CNT_W-1:0]  cycle_count
);

  // A zero timeout would make every wait expire immediately.
  if (MEM_TIMEOUT < 1) begin : g_bad_timeout
    $error("cpu_sequencer: MEM_TIMEOUT must be at least 1");
  end

  seq_state_t        state_q;
  seq_state_t        state_nxt;
  logic              commit;
  logic              disp_ld;
  logic              tmo_hit;
  logic              is_exit;
  logic [DISP_W-1:0] display_q;

  assign is_exit = (sys_v0 == DATA_W'(SYSCALL_EXIT));

`ifdef SEQ_TIMEOUT_EN
  // Down-counter loaded with MEM_TIMEOUT-1; reaching zero while still
  // waiting marks the MEM_TIMEOUT-th consecutive unanswered request cycle.
  localparam int TMR_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(MEM_TIMEOUT - 1);

  logic [TMR_W-1:0] tmr_q;
  logic             waiting;
  logic             err_q;

  assign waiting = ((state_q == ST_FETCH) && !imem_ack) ||
                   ((state_q == ST_MEM)   && !dmem_ack);
  assign tmo_hit = waiting && (tmr_q == '0);
  assign err     = err_q;

  // Wait timer: counts down only while a request is unanswered, reloads otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q <= TMR_LOAD;
    end else if (waiting && !tmo_hit) begin
      tmr_q <= tmr_q - TMR_W'(1);
    end else begin
      tmr_q <= TMR_LOAD;
    end
  end

  // Sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (tmo_hit) begin
      err_q <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state and strobe decode; every strobe is a single-cycle pulse per instruction.
  always_comb begin
    state_nxt = state_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    reg_we    = 1'b0;
    commit    = 1'b0;
    disp_ld   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we     = 1'b1;
          state_nxt = ST_DECODE;
        end else if (tmo_hit) begin
          state_nxt = ST_HALT;
        end
      end
      ST_DECODE: begin
        if (is_syscall && is_exit) begin
          state_nxt = ST_HALT;
        end else if (is_syscall) begin
          disp_ld = 1'b1;
          commit  = 1'b1;
        end else begin
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (is_load || is_store) begin
          state_nxt = ST_MEM;
        end else if (writes_reg) begin
          state_nxt = ST_WB;
        end else begin
          commit = 1'b1;
        end
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_ack) begin
          if (is_store) begin
            commit = 1'b1;
          end else begin
            state_nxt = ST_WB;
          end
        end else if (tmo_hit) begin
          state_nxt = ST_HALT;
        end
      end
      ST_WB: begin
        reg_we = 1'b1;
        commit = 1'b1;
      end
      ST_HALT: begin
        state_nxt = ST_HALT;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // run is only looked at on the commit boundary.
    if (commit) begin
      state_nxt = run ? ST_FETCH : ST_IDLE;
    end
  end

  assign pc_we  = commit;
  assign state  = state_q;
  assign halted = (state_q == ST_HALT);

  // Print-syscall latch holds the low DISP_W bits of $a0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      display_q <= '0;
    end else if (disp_ld) begin
      display_q <= sys_a0[DISP_W-1:0];
    end
  end

  assign display_syscall = display_q;

  seq_counters #(
    .CNT_W (CNT_W)
  ) u_counters (
    .clk         (clk),
    .rst_n       (rst_n),
    .cyc_inc     ((state_q != ST_IDLE) && (state_q != ST_HALT)),
    .instr_inc   (commit),
    .cycle_count (cycle_count),
    .instr_count (instr_count)
  );

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized self-checking bench for cpu_sequencer. Expected results come
// from a per-instruction cost model (cycles and strobe counts per class).
module tb_cpu_sequencer;

  localparam int DATA_W      = 32;
  localparam int DISP_W      = 32;
  localparam int CNT_W       = 32;
  localparam int MEM_TIMEOUT = 4;

  localparam int C_ALU   = 0;
  localparam int C_BR    = 1;
  localparam int C_LOAD  = 2;
  localparam int C_STORE = 3;
  localparam int C_SYS   = 4;
  localparam int C_EXIT  = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              run = 1'b0;
  logic              is_load = 1'b0;
  logic              is_store = 1'b0;
  logic              writes_reg = 1'b0;
  logic              is_syscall = 1'b0;
  logic [DATA_W-1:0] sys_v0 = '0;
  logic [DATA_W-1:0] sys_a0 = '0;
  logic              imem_req;
  logic              imem_ack = 1'b0;
  logic              dmem_req;
  logic              dmem_we;
  logic              dmem_ack = 1'b0;
  logic              ir_we;
  logic              pc_we;
  logic              reg_we;
  logic [2:0]        state;
  logic              halted;
  logic              err;
  logic [DISP_W-1:0] display_syscall;
  logic [CNT_W-1:0]  instr_count;
  logic [CNT_W-1:0]  cycle_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [CNT_W-1:0]  exp_cyc;
  logic [CNT_W-1:0]  exp_ins;
  logic [DISP_W-1:0] exp_disp;

  cpu_sequencer #(
    .DATA_W      (DATA_W),
    .DISP_W      (DISP_W),
    .CNT_W       (CNT_W),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .run             (run),
    .is_load         (is_load),
    .is_store        (is_store),
    .writes_reg      (writes_reg),
    .is_syscall      (is_syscall),
    .sys_v0          (sys_v0),
    .sys_a0          (sys_a0),
    .imem_req        (imem_req),
    .imem_ack        (imem_ack),
    .dmem_req        (dmem_req),
    .dmem_we         (dmem_we),
    .dmem_ack        (dmem_ack),
    .ir_we           (ir_we),
    .pc_we           (pc_we),
    .reg_we          (reg_we),
    .state           (state),
    .halted          (halted),
    .err             (err),
    .display_syscall (display_syscall),
    .instr_count     (instr_count),
    .cycle_count     (cycle_count)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one instruction from its first FETCH cycle (entered at posedge+1)
  // until commit or halt, acking memories after the requested latencies.
  task automatic run_instr(input int cls, input int lat_f, input int lat_m,
                           input logic [31:0] a0, input bit drop_run);
    int n_ir = 0, n_pc = 0, n_rg = 0, n_ireq = 0, n_dreq = 0, n_dwe = 0;
    int f_wait = 0, m_wait = 0, cyc = 0, cost;
    bit done = 0;
    bit mem_op, wb_op, exec_op;
    logic [31:0] v0;

    mem_op  = (cls == C_LOAD) || (cls == C_STORE);
    wb_op   = (cls == C_ALU) || (cls == C_LOAD);
    exec_op = (cls <= C_STORE);

    is_load    = (cls == C_LOAD);
    is_store   = (cls == C_STORE);
    writes_reg = wb_op;
    is_syscall = (cls >= C_SYS);
    v0 = $urandom_range(0, 15);
    if (cls == C_EXIT) v0 = 32'd10;
    else if (cls == C_SYS && v0 == 32'd10) v0 = 32'd1;
    sys_v0 = v0;
    sys_a0 = a0;

    chk("instr_start_state", state, 3'd1);
    while (!done && cyc < 100) begin
      imem_ack = imem_req ? (f_wait == lat_f) : 1'($urandom_range(0, 1));
      if (imem_req) f_wait++;
      dmem_ack = dmem_req ? (m_wait == lat_m) : 1'($urandom_range(0, 1));
      if (dmem_req) m_wait++;
      if (drop_run && state != 3'd1) run = 1'b0;
      @(negedge clk);
      n_ir   += int'(ir_we);
      n_pc   += int'(pc_we);
      n_rg   += int'(reg_we);
      n_ireq += int'(imem_req);
      n_dreq += int'(dmem_req);
      if (dmem_req) n_dwe += int'(dmem_we);
      if (pc_we) done = 1;
      @(posedge clk);
      #1;
      cyc++;
      if (halted) done = 1;
    end
    chk("instr_done", done, 1'b1);

    cost = lat_f + 2 + (exec_op ? 1 : 0) + (mem_op ? lat_m + 1 : 0) + (wb_op ? 1 : 0);
    exp_cyc = exp_cyc + CNT_W'(cost);
    if (cls != C_EXIT) exp_ins = exp_ins + CNT_W'(1);
    if (cls == C_SYS) exp_disp = a0;

    chk("ir_we_pulses", n_ir, 1);
    chk("pc_we_pulses", n_pc, (cls == C_EXIT) ? 0 : 1);
    chk("reg_we_pulses", n_rg, wb_op ? 1 : 0);
    chk("imem_req_cycles", n_ireq, lat_f + 1);
    chk("dmem_req_cycles", n_dreq, mem_op ? lat_m + 1 : 0);
    chk("dmem_we_cycles", n_dwe, (cls == C_STORE) ? lat_m + 1 : 0);
    chk("instr_count", instr_count, exp_ins);
    chk("cycle_count", cycle_count, exp_cyc);
    chk("display_syscall", display_syscall, exp_disp);
    if (cls == C_EXIT) begin
      chk("exit_state", state, 3'd6);
      chk("exit_halted", halted, 1'b1);
    end else begin
      chk("post_commit_state", state, drop_run ? 3'd0 : 3'd1);
    end
  endtask

  // Sit in IDLE a few cycles, then restart execution.
  task automatic resume_run();
    repeat (3) @(posedge clk);
    #1;
    chk("idle_state", state, 3'd0);
    chk("idle_cycle_frozen", cycle_count, exp_cyc);
    run = 1'b1;
    @(posedge clk);
    #1;
    chk("resume_fetch", state, 3'd1);
  endtask

  initial begin
    int cls, lat_f, lat_m, cyc, n;
    bit dr;

    exp_cyc  = '0;
    exp_ins  = '0;
    exp_disp = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", state, 3'd0);
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_strobes", {ir_we, pc_we, reg_we, dmem_req}, 4'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_counts", {instr_count, cycle_count}, 64'd0);
    chk("rst_display", display_syscall, '0);

    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_no_run", state, 3'd0);
    run = 1'b1;
    @(posedge clk);
    #1;

    // Directed shapes from the plan, then a randomized stream.
    run_instr(C_ALU, 1, 0, 32'h0, 0);
    run_instr(C_LOAD, 0, 3, 32'h0, 0);
    run_instr(C_STORE, 0, 3, 32'h0, 0);
    run_instr(C_SYS, 1, 0, 32'h0000_1234, 0);
    run_instr(C_LOAD, 1, 2, 32'h0, 1);
    resume_run();

    for (int i = 0; i < 40; i++) begin
      cls   = $urandom_range(0, 4);
      lat_f = $urandom_range(0, 3);
      lat_m = $urandom_range(0, 3);
      dr    = ($urandom_range(0, 5) == 0);
      run_instr(cls, lat_f, lat_m, $urandom, dr);
      if (dr) resume_run();
    end

    // Reset asserted while a load sits in MEM with dmem_req high.
    is_load = 1'b1; is_store = 1'b0; writes_reg = 1'b1; is_syscall = 1'b0;
    dmem_ack = 1'b0;
    cyc = 0;
    while (!dmem_req && cyc < 20) begin
      imem_ack = imem_req;
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("mem_reached", dmem_req, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midmem_rst_dmem_req", dmem_req, 1'b0);
    chk("midmem_rst_state", state, 3'd0);
    chk("midmem_rst_halted", halted, 1'b0);
    chk("midmem_rst_counts", {instr_count, cycle_count}, 64'd0);
    chk("midmem_rst_display", display_syscall, '0);
    exp_cyc = '0; exp_ins = '0; exp_disp = '0;
    imem_ack = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Print, ordinary work, then exit; HALT must ignore run.
    run_instr(C_SYS, 0, 0, 32'h0000_1234, 0);
    run_instr(C_ALU, 2, 0, 32'h0, 0);
    run_instr(C_EXIT, 1, 0, 32'hdead_beef, 0);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      n += int'(imem_req);
    end
    chk("halt_no_imem_req", n, 0);
    chk("halt_state_held", state, 3'd6);
    chk("halt_display_held", display_syscall, 32'h0000_1234);
    chk("halt_cycle_frozen", cycle_count, exp_cyc);

    // Fetch that is never acknowledged.
    rst_n = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    run = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("tmo_fetch_entry", state, 3'd1);
`ifdef SEQ_TIMEOUT_EN
    n = 0;
    while (state == 3'd1 && n < 20) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk("tmo_wait_cycles", n, MEM_TIMEOUT);
    chk("tmo_state", state, 3'd6);
    chk("tmo_imem_req", imem_req, 1'b0);
    chk("tmo_err", err, 1'b1);
    chk("tmo_halted", halted, 1'b1);
`else
    n = 0;
    repeat (30) begin
      @(negedge clk);
      n += int'(imem_req);
    end
    chk("nowait_imem_req", n, 30);
    chk("nowait_err", err, 1'b0);
    chk("nowait_state", state, 3'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
